// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, LFSR constants and quadrant type
// for the NCO phase-fold front end.
package nco_pkg;
  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 14;

  // Galois form of x^16+x^14+x^13+x^11+1 (right shift)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;
endpackage

// File: rtl/nco_phase_acc.sv
// nco_phase_acc: phase accumulator (clear beats advance) plus
// optional dither LFSR, enabled by NCO_DITHER_EN.
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [PHASE_W-1:0] i_ftw,
  output logic [PHASE_W-1:0] o_acc,
  output logic [15:0]        o_lfsr
);

  logic [PHASE_W-1:0] r_acc;

  // accumulate tuning word; clear has priority, wrap silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_ftw;
    end
  end

  assign o_acc = r_acc;

`ifdef NCO_DITHER_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]}
                    ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);

  // dither sequence advances once per launched sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign o_lfsr = r_lfsr;
`else
  assign o_lfsr = 16'h0;
`endif

endmodule

// File: rtl/nco_phase_fold.sv
// nco_phase_fold: phase offset, quarter-wave address fold,
// sign restore and valid pipeline. Dither: NCO_DITHER_EN.
module nco_phase_fold
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     phase_clr,
  input  logic [PHASE_W-1:0]       ftw,
  input  logic [PHASE_W-1:0]       phase_off,
  output logic [ADDR_W-1:0]        lut_addr,
  input  logic signed [DATA_W-1:0] lut_data,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic [PHASE_W-1:0]       phase_out
);

  localparam int TRUNC_W = PHASE_W - 2 - ADDR_W;
  localparam int DITH_W  = (TRUNC_W < 16) ? TRUNC_W : 16;
  localparam logic [15:0] DMASK =
    16'((32'd1 << DITH_W) - 32'd1);

  logic [PHASE_W-1:0] w_acc;
  logic [PHASE_W-1:0] w_p;
  logic [15:0]        w_lfsr;
  quadrant_t          w_q;
  logic [ADDR_W-1:0]  w_idx;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_mirror;
  logic               w_neg;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_vld_a;
  logic               r_vld_b;

  nco_phase_acc #(
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en),
    .i_clr  (phase_clr),
    .i_ftw  (ftw),
    .o_acc  (w_acc),
    .o_lfsr (w_lfsr)
  );

  assign phase_out = w_acc;
  assign w_p   = w_acc + phase_off
               + PHASE_W'(w_lfsr & DMASK);
  assign w_q   = quadrant_t'(w_p[PHASE_W-1 -: 2]);
  assign w_idx = w_p[PHASE_W-3 -: ADDR_W];

  // odd quadrants read the LUT backwards, lower half is negative
  always_comb begin
    w_mirror = 1'b0;
    w_neg    = 1'b0;
    unique case (w_q)
      Q0: ;
      Q1: w_mirror = 1'b1;
      Q2: w_neg    = 1'b1;
      Q3: begin
        w_mirror = 1'b1;
        w_neg    = 1'b1;
      end
    endcase
  end

  assign w_addr = w_mirror ? ~w_idx : w_idx;

  // stage A: launch address and sign on en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_addr <= '0;
      r_neg_a  <= 1'b0;
      r_vld_a  <= 1'b0;
    end else begin
      r_vld_a <= en;
      if (en) begin
        lut_addr <= w_addr;
        r_neg_a  <= w_neg;
      end
    end
  end

  // stage B: carry sign alongside the LUT read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_b <= 1'b0;
      r_vld_b <= 1'b0;
    end else begin
      r_vld_b <= r_vld_a;
      if (r_vld_a) begin
        r_neg_b <= r_neg_a;
      end
    end
  end

  // stage C: restore sign, publish sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= r_vld_b;
      if (r_vld_b) begin
        sample_out <= r_neg_b ? -lut_data : lut_data;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_fold.sv
// tb_nco_phase_fold: random and directed stimulus against a
// phase-arithmetic reference model with a 1-cycle LUT model.
module tb_nco_phase_fold;

  logic               clk;
  logic               rst;
  logic               en;
  logic               phase_clr;
  logic [31:0]        ftw;
  logic [31:0]        phase_off;
  logic [9:0]         lut_addr;
  logic signed [13:0] lut_data;
  logic signed [13:0] sample_out;
  logic               sample_valid;
  logic [31:0]        phase_out;

  typedef struct {
    int                 due;
    logic signed [13:0] val;
  } exp_t;

  logic signed [13:0] lut [1024];
  exp_t               expq [$];
  logic [31:0]        macc;
  int                 maddr;
  logic signed [13:0] mlast;
  int                 ecnt;
  int                 n_chk;
  int                 n_err;

  nco_phase_fold dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .phase_clr    (phase_clr),
    .ftw          (ftw),
    .phase_off    (phase_off),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .phase_out    (phase_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) lut_data <= lut[lut_addr];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic c,
                      input logic [31:0] f,
                      input logic [31:0] o);
    logic [31:0] p;
    int quad;
    int idx;
    int v;
    exp_t t;
    en = e;
    phase_clr = c;
    ftw = f;
    phase_off = o;
    @(posedge clk);
    if (e) begin
      p = macc + o;
      quad = int'(p >> 30);
      idx = int'((p >> 20) & 32'd1023);
      maddr = (quad == 1 || quad == 3) ? 1023 - idx : idx;
      v = int'(lut[maddr]);
      if (quad >= 2) v = -v;
      t.due = ecnt + 2;
      t.val = 14'(v);
      expq.push_back(t);
    end
    if (c) macc = 32'd0;
    else if (e) macc = macc + f;
    @(negedge clk);
    check("phase_out", phase_out, macc);
    check("lut_addr", 32'(lut_addr), 32'(maddr));
    if (expq.size() > 0 && expq[0].due == ecnt) begin
      check("valid", 32'(sample_valid), 32'd1);
      mlast = expq[0].val;
      void'(expq.pop_front());
    end else begin
      check("valid", 32'(sample_valid), 32'd0);
    end
    check("sample", 32'(sample_out), 32'(mlast));
    ecnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    phase_clr = 1'b0;
    ftw = '0;
    phase_off = '0;
    macc = '0;
    maddr = 0;
    mlast = '0;
    ecnt = 0;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 1024; i++)
      lut[i] = 14'($urandom_range(1, 8191));
    lut[0] = 14'sd100;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_addr", 32'(lut_addr), 32'd0);
    check("rst_phase", phase_out, 32'd0);
    rst = 1'b0;

    // zero phase: address 0, positive lut[0]
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 32'd0);
    idle(3);
    check("zero_sample", 32'(sample_out), 32'd100);

    // half-cycle offset negates lut[0]
    step(1'b1, 1'b0, 32'd0, 32'h8000_0000);
    idle(3);
    check("half_addr", 32'(lut_addr), 32'd0);
    check("half_sample", 32'(sample_out), 32'hFFFF_FF9C);

    // quarter-cycle offset mirrors to the top entry
    step(1'b1, 1'b0, 32'd0, 32'h4000_0000);
    idle(3);
    check("qtr_addr", 32'(lut_addr), 32'd1023);
    check("qtr_sample", 32'(sample_out), 32'(lut[1023]));

    // accumulator wrap
    step(1'b0, 1'b1, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'hC000_0000, 32'd0);
    check("wrap1", phase_out, 32'hC000_0000);
    step(1'b1, 1'b0, 32'hC000_0000, 32'd0);
    check("wrap2", phase_out, 32'h8000_0000);
    idle(3);

    // clear and en together: clear wins, sample still launched
    step(1'b1, 1'b1, 32'h1234_5678, 32'd0);
    check("clr_en_phase", phase_out, 32'd0);
    idle(3);

    // full sweep one entry per cycle, then four per cycle
    step(1'b0, 1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 4100; i++)
      step(1'b1, 1'b0, 32'h0010_0000, 32'd0);
    for (int i = 0; i < 1100; i++)
      step(1'b1, 1'b0, 32'h0040_0000, 32'h0123_4567);
    idle(3);

    // random en / clear / tuning / offset
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0),
           $urandom(), $urandom());
    idle(3);

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, $urandom(), $urandom());
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_sample", 32'(sample_out), 32'd0);
    check("mid_rst_addr", 32'(lut_addr), 32'd0);
    check("mid_rst_phase", phase_out, 32'd0);
    expq.delete();
    macc = '0;
    maddr = 0;
    mlast = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, $urandom(), $urandom());
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
